// File: rtl/polyvec_acc_stream.sv
// Streaming polynomial-vector accumulator: sums kn polynomials pair-by-pair into a
// local accumulator, then streams each accumulated pair out reduced modulo Q.
module polyvec_acc_stream #(
  parameter int K_MAX = 4,
  parameter int DEPTH = 8,
  parameter int W     = 16,
  parameter int Q     = 3329
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           k_num,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  in_d1,
  input  logic signed [W-1:0]  in_d2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_d1,
  output logic [W-1:0]         out_d2,
  output logic [DEPTH-2:0]     out_index,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int P  = 2 ** (DEPTH - 1);
  localparam int PW = DEPTH - 1;
  localparam int AW = W + 3;
  localparam logic [2:0]    KMAX3 = 3'(K_MAX);
  localparam logic [PW-1:0] PLAST = PW'(P - 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t r_state, w_next;

  logic [2:0]    r_k, r_kn;
  logic [PW-1:0] r_p, r_rd_p;
  logic          r_iss_done;
  logic          r_vld_p0, r_vld_p1;
  logic          r_done, r_err;

  logic signed [AW-1:0] r_acc_d1 [P];
  logic signed [AW-1:0] r_acc_d2 [P];
  logic signed [AW-1:0] r_d1_p0, r_d2_p0;
  logic [PW-1:0]        r_idx_p0, r_idx_p1;
  logic [W-1:0]         r_d1_p1, r_d2_p1;

  // Nonnegative residue, valid for negative sums as well.
  function automatic logic [W-1:0] mod_q(input logic signed [AW-1:0] x);
    int r;
    r = int'(x) % Q;
    if (r < 0) r = r + Q;
    return r[W-1:0];
  endfunction

  logic w_kn_ok, w_start_ok, w_in_hs, w_last_in, w_out_hs, w_last_out;
  logic w_adv_p0, w_adv_p1, w_issue;
  logic signed [AW-1:0] w_ext1, w_ext2;

  assign w_kn_ok    = (k_num != 3'd0) && (k_num <= KMAX3);
  assign w_start_ok = start && (r_state == IDLE) && w_kn_ok;
  assign w_in_hs    = in_valid && (r_state == ACC);
  assign w_last_in  = w_in_hs && (r_p == PLAST) && (r_k == r_kn - 3'd1);
  assign w_out_hs   = r_vld_p1 && out_ready;
  assign w_last_out = w_out_hs && (r_idx_p1 == PLAST);
  assign w_adv_p1   = !r_vld_p1 || out_ready;
  assign w_adv_p0   = !r_vld_p0 || w_adv_p1;
  assign w_issue    = (r_state == OUT) && !r_iss_done && w_adv_p0;
  assign w_ext1     = {{3{in_d1[W-1]}}, in_d1};
  assign w_ext2     = {{3{in_d2[W-1]}}, in_d2};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_next = ACC;
      ACC:     if (w_last_in)  w_next = OUT;
      OUT:     if (w_last_out) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_kn       <= '0;
      r_p        <= '0;
      r_rd_p     <= '0;
      r_iss_done <= 1'b0;
      r_vld_p0   <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_last_out;
      r_err   <= start && (r_state == IDLE) && !w_kn_ok;
      if (w_start_ok) begin
        r_kn <= k_num;
        r_k  <= '0;
        r_p  <= '0;
      end
      if (w_in_hs) begin
        r_p <= r_p + PW'(1);
        if (r_p == PLAST) r_k <= r_k + 3'd1;
      end
      if (w_last_in) begin
        r_rd_p     <= '0;
        r_iss_done <= 1'b0;
      end
      if (w_issue) begin
        r_rd_p <= r_rd_p + PW'(1);
        if (r_rd_p == PLAST) r_iss_done <= 1'b1;
      end
      if (w_adv_p0) r_vld_p0 <= w_issue;
      if (w_adv_p1) r_vld_p1 <= r_vld_p0;
    end
  end

  // Accumulate stage: k = 0 overwrites, so no clearing is needed between runs.
  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_acc_d1[r_p] <= (r_k == 3'd0) ? w_ext1 : r_acc_d1[r_p] + w_ext1;
      r_acc_d2[r_p] <= (r_k == 3'd0) ? w_ext2 : r_acc_d2[r_p] + w_ext2;
    end
  end

  // Stage p0: accumulator read.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_d1_p0  <= r_acc_d1[r_rd_p];
      r_d2_p0  <= r_acc_d2[r_rd_p];
      r_idx_p0 <= r_rd_p;
    end
  end

  // Stage p1: modular reduction into the output register.
  always_ff @(posedge clk) begin
    if (w_adv_p1 && r_vld_p0) begin
      r_d1_p1  <= mod_q(r_d1_p0);
      r_d2_p1  <= mod_q(r_d2_p0);
      r_idx_p1 <= r_idx_p0;
    end
  end

  assign in_ready  = (r_state == ACC);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_vld_p1;
  assign out_d1    = r_vld_p1 ? r_d1_p1 : '0;
  assign out_d2    = r_vld_p1 ? r_d2_p1 : '0;
  assign out_index = r_vld_p1 ? r_idx_p1 : '0;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_polyvec_acc_stream.sv
// Bench for polyvec_acc_stream: directed scenarios plus randomized runs against
// a sum-then-reduce reference model.
module tb_polyvec_acc_stream;

  localparam int K_MAX = 4;
  localparam int DEPTH = 8;
  localparam int W     = 16;
  localparam int Q     = 3329;
  localparam int P     = 128;

  logic                clk = 1'b0;
  logic                reset, start, in_valid, out_ready;
  logic [2:0]          k_num;
  logic signed [W-1:0] in_d1, in_d2;
  logic                in_ready, out_valid, busy, done, err;
  logic [W-1:0]        out_d1, out_d2;
  logic [DEPTH-2:0]    out_index;

  polyvec_acc_stream #(.K_MAX(K_MAX), .DEPTH(DEPTH), .W(W), .Q(Q)) dut (
    .clk(clk), .reset(reset), .start(start), .k_num(k_num),
    .in_valid(in_valid), .in_ready(in_ready), .in_d1(in_d1), .in_d2(in_d2),
    .out_valid(out_valid), .out_ready(out_ready), .out_d1(out_d1), .out_d2(out_d2),
    .out_index(out_index), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int in_a [4][P];
  int in_b [4][P];
  int exp1 [P];
  int exp2 [P];

  function automatic int modq(input int s);
    int r;
    r = s % Q;
    if (r < 0) r = r + Q;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input int a, input int b);
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < P; p++) begin
        in_a[k][p] = a;
        in_b[k][p] = b;
      end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < P; p++) begin
        in_a[k][p] = int'($urandom_range(0, 65535)) - 32768;
        in_b[k][p] = int'($urandom_range(0, 65535)) - 32768;
      end
  endtask

  task automatic do_start(input int kn);
    k_num = 3'(kn);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL start_accept: busy=%b in_ready=%b err=%b, required 1 1 0", busy, in_ready, err);
    end
  endtask

  // Feeds kn polynomials; optional idle gaps, a start pulse at input n, early stop.
  task automatic feed(input int kn, input int gaps, input int pulse_at, input int stop_after);
    int guard, n;
    bit bad_ov, bad_err;
    bad_ov = 0; bad_err = 0; n = 0;
    for (int k = 0; k < kn; k++)
      for (int p = 0; p < P; p++) begin
        if (stop_after >= 0 && n == stop_after) begin
          in_valid = 1'b0;
          return;
        end
        if (gaps > 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(0, gaps)) begin
            if (out_valid) bad_ov = 1;
            step();
          end
        end
        in_valid = 1'b1;
        in_d1 = W'(in_a[k][p]);
        in_d2 = W'(in_b[k][p]);
        guard = 0;
        while (!in_ready && guard < 50) begin step(); guard++; end
        if (guard >= 50) begin
          errors++; checks++;
          $display("FAIL feed_timeout: in_ready=%b at k=%0d p=%0d, required 1", in_ready, k, p);
          in_valid = 1'b0;
          return;
        end
        if (out_valid) bad_ov = 1;
        if (n == pulse_at) begin start = 1'b1; k_num = 3'd2; end
        step();
        start = 1'b0;
        if (err) bad_err = 1;
        n++;
      end
    in_valid = 1'b0;
    checks++;
    if (bad_ov || bad_err) begin
      errors++;
      $display("FAIL feed_side: out_valid_seen=%0d err_seen=%0d, required 0 0", bad_ov, bad_err);
    end
  endtask

  // Collects all P pairs and checks latency, order, values, holds and done timing.
  task automatic collect(input int kn, input int stall_at, input int stall_len,
                         input bit rnd, input int pulse_at);
    int lat, hold, s1, s2;
    bit bad_err;
    bad_err = 0;
    for (int p = 0; p < P; p++) begin
      s1 = 0; s2 = 0;
      for (int k = 0; k < kn; k++) begin s1 += in_a[k][p]; s2 += in_b[k][p]; end
      exp1[p] = modq(s1);
      exp2[p] = modq(s2);
    end
    out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL out_latency: first out_valid after %0d cycles, required 2", lat);
      if (lat >= 20) return;
    end
    for (int i = 0; i < P; i++) begin
      hold = (i == stall_at) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s <= hold; s++) begin
        out_ready = (s == hold);
        if (i == pulse_at && s == hold) begin start = 1'b1; k_num = 3'd1; end
        checks++;
        if (out_valid !== 1'b1 || out_index !== 7'(i) ||
            out_d1 !== 16'(exp1[i]) || out_d2 !== 16'(exp2[i])) begin
          errors++;
          $display("FAIL out_pair: valid=%b idx=%0d d1=%0d d2=%0d, required 1 %0d %0d %0d",
                   out_valid, out_index, out_d1, out_d2, i, exp1[i], exp2[i]);
        end
        step();
        start = 1'b0;
        if (err) bad_err = 1;
      end
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_d1 !== '0 || out_d2 !== '0 || out_index !== '0 || bad_err) begin
      errors++;
      $display("FAIL done_pulse: done=%b valid=%b busy=%b d1=%0d d2=%0d idx=%0d err_seen=%0d, required 1 0 0 0 0 0 0",
               done, out_valid, busy, out_d1, out_d2, out_index, bad_err);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_single: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; k_num = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_d1 = '0; in_d2 = '0;
    repeat (3) step();
    checks++;
    if (busy !== 0 || in_ready !== 0 || out_valid !== 0 || done !== 0 || err !== 0 ||
        out_d1 !== '0 || out_d2 !== '0 || out_index !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b in_ready=%b out_valid=%b done=%b err=%b, required all 0",
               busy, in_ready, out_valid, done, err);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_scn1();
    fill_const(1000, -1);
    do_start(3);
    feed(3, 0, -1, -1);
    collect(3, -1, 0, 0, -1);
  endtask

  task automatic test_scn2();
    fill_const(3328, -32768);
    do_start(4);
    feed(4, 0, -1, -1);
    collect(4, -1, 0, 0, -1);
  endtask

  task automatic test_stall_hold();
    for (int p = 0; p < P; p++) begin in_a[0][p] = p; in_b[0][p] = -p; end
    do_start(1);
    feed(1, 0, -1, -1);
    collect(1, 10, 5, 0, -1);
  endtask

  task automatic test_err();
    for (int t = 0; t < 2; t++) begin
      k_num = (t == 0) ? 3'd0 : 3'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse: k_num=%0d err=%b busy=%b in_ready=%b, required 1 0 0", k_num, err, busy, in_ready);
      end
      step();
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL err_single: err=%b busy=%b in_ready=%b, required 0 0 0", err, busy, in_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_random();
    do_start(2);
    feed(2, 0, -1, P + 40);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 0 || in_ready !== 0 || out_valid !== 0 || done !== 0 || err !== 0 ||
        out_d1 !== '0 || out_d2 !== '0 || out_index !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b in_ready=%b out_valid=%b done=%b err=%b, required all 0",
               busy, in_ready, out_valid, done, err);
    end
    step();
    reset = 1'b0;
    fill_const(7, 7);
    do_start(2);
    feed(2, 0, -1, -1);
    collect(2, -1, 0, 0, -1);
  endtask

  task automatic test_start_ignored();
    fill_random();
    do_start(2);
    feed(2, 0, 50, -1);
    collect(2, -1, 0, 0, 20);
  endtask

  task automatic test_back_to_back();
    fill_random();
    do_start(4);
    feed(4, 0, -1, -1);
    collect(4, -1, 0, 0, -1);
    fill_random();
    do_start(3);
    feed(3, 0, -1, -1);
    collect(3, -1, 0, 0, -1);
  endtask

  task automatic test_random();
    int kn;
    for (int it = 0; it < 3; it++) begin
      fill_random();
      kn = int'($urandom_range(1, 4));
      do_start(kn);
      feed(kn, 2, -1, -1);
      collect(kn, int'($urandom_range(0, P - 1)), int'($urandom_range(1, 6)), 1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_scn1();
    test_scn2();
    test_stall_hold();
    test_err();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/polyvec_acc_stream.md
POLYVEC_ACC_STREAM -- requirements
Module: polyvec_acc_stream

Interface
REQ-001 SHALL have parameter K_MAX, default 4, the maximum polynomials per vector (legal range 1..4).
REQ-002 SHALL have parameter DEPTH, default 8, where coefficients = 2^DEPTH and pairs P = 2^(DEPTH-1).
REQ-003 SHALL have parameter W, default 16, the signed input coefficient width.
REQ-004 SHALL have parameter Q, default 3329, the modulus.
REQ-005 SHALL have port clk  in  1, the clock; all logic is rising-edge.
REQ-006 SHALL have port reset  in  1, asynchronous, active-high.
REQ-007 SHALL have port start  in  1, a one-cycle request that begins an operation.
REQ-008 SHALL have port k_num  in  3, the number of polynomials to accumulate, sampled when start is accepted.
REQ-009 SHALL have port in_valid  in  1, the input pair valid.
REQ-010 SHALL have port in_ready  out  1, the input pair accepted this cycle when in_valid is also high.
REQ-011 SHALL have ports in_d1 and in_d2  in  W, the signed even and odd coefficients of the current pair.
REQ-012 SHALL have port out_valid  out  1, the output pair valid.
REQ-013 SHALL have port out_ready  in  1, the downstream accept.
REQ-014 SHALL have ports out_d1 and out_d2  out  W, the unsigned reduced coefficients in [0,Q-1].
REQ-015 SHALL have port out_index  out  DEPTH-1, the pair index of out_d1 and out_d2.
REQ-016 SHALL have port busy  out  1, high in any state other than IDLE.
REQ-017 SHALL have port done  out  1, a one-cycle pulse after the final output handshake.
REQ-018 SHALL have port err  out  1, a one-cycle pulse when start is rejected.

Function
REQ-019 SHALL implement FSM states IDLE, ACC and OUT.
REQ-020 SHALL accept start only in IDLE with 1 <= k_num <= K_MAX: latch kn = k_num, set k = 0 and pair index p = 0, and go to ACC on the next edge.
REQ-021 SHALL ignore start in IDLE when k_num = 0 or k_num > K_MAX, pulse err the next cycle, and stay in IDLE.
REQ-022 SHALL ignore start while busy, with no err pulse and no state change.
REQ-023 SHALL drive in_ready = 1 exactly when the state is ACC.
REQ-024 SHALL, on each ACC handshake, write acc[p] = in when k = 0 and acc[p] = acc[p] + in when k > 0, for both lanes independently.
REQ-025 SHALL hold the accumulator as signed W+3 bits so that no intermediate overflow occurs for any input values.
REQ-026 SHALL advance p on each handshake; at p = P-1, p wraps to 0 and k increments.
REQ-027 SHALL go from ACC to OUT when the handshake at p = P-1 coincides with k = kn-1.
REQ-028 SHALL require no accumulator clearing between operations, because k = 0 overwrites every entry.
REQ-029 SHALL present pairs in OUT in order p = 0..P-1, with out_dX = acc[p][X] mod Q as the mathematical nonnegative residue, including negative sums.
REQ-030 SHALL assert the first out_valid exactly 2 cycles after the edge that accepted the final input.
REQ-031 SHALL sustain one pair per cycle while out_ready = 1 (full throughput, with no bubbles after the first).
REQ-032 SHALL hold out_d1, out_d2 and out_index stable while out_valid = 1 and out_ready = 0, for any duration.
REQ-033 SHALL drop out_valid in the cycle after the handshake of p = P-1, pulse done in that same cycle, and return the FSM to IDLE.
REQ-034 SHALL accept a start in the cycle after done.
REQ-035 SHALL produce out_valid only in OUT, and SHALL never assert it while in_ready = 1.
REQ-036 SHALL drive out_d1, out_d2 and out_index as 0 when out_valid = 0.

Reset
REQ-037 SHALL, on reset assertion at any time including mid-ACC or mid-OUT, immediately force state IDLE, k = 0, p = 0, in_ready = 0, out_valid = 0, busy = 0, done = 0, err = 0, out_d1 = out_d2 = 0 and out_index = 0.
REQ-038 SHALL leave the accumulator contents undefined after reset, with no effect on results because of REQ-028.
REQ-039 SHALL need no start or handshake in the first cycle after reset deassertion in order to be ready: the block is in IDLE and able to accept start.

Verification
REQ-040 SHALL cover scenario 1: K_MAX=4, k_num=3, every pair in_d1 = 1000 and in_d2 = -1 -> all 128 outputs are d1 = 3000 and d2 = 3326, out_index runs 0..127, then done.
REQ-041 SHALL cover scenario 2: k_num=4, all in_d1 = 3328 and in_d2 = -32768 -> d1 = 3325 and d2 = 2088 for every pair.
REQ-042 SHALL cover scenario 3: k_num=1 with in_d1 = p and in_d2 = -p, out_ready low for 5 cycles while pair 10 is presented -> outputs 10 and 3319 held stable with out_index = 10; pairs 0..127 are then otherwise contiguous.
REQ-043 SHALL cover scenario 4: start with k_num=0, then with k_num=5 -> err pulses twice, busy stays 0, in_ready stays 0.
REQ-044 SHALL cover scenario 5: reset asserted at k=1, p=40, then start with k_num=2 and all inputs 7 -> all outputs are 14, with no residue from the aborted run.
REQ-045 SHALL cover scenario 6: start pulsed during ACC and during OUT -> ignored; the results and done timing are identical to a run without those pulses.
